and_pair_checker: RTL

- Response-side counterpart of the and2 stimulus bench: samples a 4-bit stimulus vector and the two and2 results (res1 = a[3]&a[2], res2 = a[1]&a[0]), recomputes the expected pair and scores it.
- Sequential scoreboard: handshake intake, vector and error counters, first-failure capture, pass/done reporting after a fixed number of vectors.
- Sits in the test harness between the and2 instances and waveform/finish logic; synthesizable so it can also run on the board.

---
 rtl/and_pair_checker_pkg.sv | 14 +
 rtl/and_pair_checker_if.sv | 9 +
 rtl/and_pair_checker_sat_counter.sv | 15 +
 rtl/and_pair_checker.sv | 57 +++++
 4 files changed

// File: rtl/and_pair_checker_pkg.sv
// and_pair_checker_pkg: shared state encodings and and2-pair result helpers.
package and_pair_checker_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  function automatic logic [1:0] and_pair(input logic [3:0] a);
    return {a[3] & a[2], a[1] & a[0]};
  endfunction
  // Unknown result bits fail the equality test and fall through to mismatch.
  function automatic logic pair_mismatch(input logic [3:0] a, input logic [1:0] r);
    if (r == and_pair(a)) return 1'b0;
    return 1'b1;
  endfunction
endpackage

// File: rtl/and_pair_checker_if.sv
// and_pair_checker_if: stimulus/result handshake between harness and checker.
interface and_pair_checker_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] stim;
  logic [1:0] res;
  modport master (output in_valid, stim, res, input in_ready);
  modport slave  (input in_valid, stim, res, output in_ready);
endinterface

// File: rtl/and_pair_checker_sat_counter.sv
// sat_counter: clearable up-counter that holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (!rst_n) q <= '0;
    else q <= clr ? '0 : (inc && !(&q)) ? q + 1'b1 : q;
  end
endmodule

// File: rtl/and_pair_checker.sv
// and_pair_checker: scores and2 result pairs against their stimulus over a fixed-length run.
module and_pair_checker
  import and_pair_checker_pkg::*;
#(
  parameter int N_VECTORS = 3,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  and_pair_checker_if.slave    bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     vec_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic                 first_err_valid,
  output logic [CNT_W-1:0]     first_err_idx,
  output logic [3:0]           first_err_stim
);
  logic [1:0] state, state_nxt;
  logic ready, clr, xfer, mis;
  always_comb begin
    clr = start && (state != ST_RUN);
    xfer = bus.in_valid && ready;
    mis = pair_mismatch(bus.stim, bus.res);
    state_nxt = clr ? ST_RUN :
                (xfer && vec_cnt == CNT_W'(N_VECTORS - 1)) ? ST_DONE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ready <= 1'b0;
      first_err_valid <= 1'b0;
      first_err_idx <= '0;
      first_err_stim <= '0;
    end else begin
      state <= state_nxt;
      ready <= state_nxt == ST_RUN;
      if (clr) begin
        first_err_valid <= 1'b0;
        first_err_idx <= '0;
        first_err_stim <= '0;
      end else if (xfer && mis && !first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_idx <= vec_cnt;
        first_err_stim <= bus.stim;
      end
    end
  end
  assign bus.in_ready = ready;
  assign busy = state == ST_RUN;
  assign done = state == ST_DONE;
  assign pass = done && err_cnt == '0;
  sat_counter #(.W(CNT_W)) u_vec (.clk(clk), .rst_n(rst_n), .clr(clr), .inc(xfer), .q(vec_cnt));
  sat_counter #(.W(CNT_W)) u_err (.clk(clk), .rst_n(rst_n), .clr(clr), .inc(xfer && mis), .q(err_cnt));
endmodule
